mapa_responder: RTL
===================

Name: mapa_responder

Overview:
- Responder side of the tile-map access protocol. Owns the 2-bit-per-cell tile RAM. Serves two initiators:
  - the renderer, through a fixed-latency colour read;
  - the game-update engine, through a read/write request port with a ready/valid handshake.
- After reset, or on a clear request, it initialises the board itself before granting any update access.

Parameters:
- MAPA_WIDTH, 40: cells per row.
- MAPA_HEIGHT, 30: cells per column.
- COORD_W, 10: width of every x/y coordinate port.
- ADDR_W, 11: RAM address width; must satisfy 2^ADDR_W >= MAPA_WIDTH*MAPA_HEIGHT.

Ports:
- clk, in, 1: single system clock; all logic is on its rising edge.
- reset, in, 1: asynchronous, active-low reset.
- clear, in, 1: synchronous request to re-initialise the board; a one-cycle pulse is sufficient.
- init_done, out, 1: high when the block is in SERVE.
- vga_read, in, 1: renderer read strobe.
- renderer_rx, in, COORD_W: renderer cell x.
- renderer_ry, in, COORD_W: renderer cell y.
- mapa_R, out, 8: cell colour, red channel.
- mapa_G, out, 8: cell colour, green channel.
- mapa_B, out, 8: cell colour, blue channel.
- update_renable, in, 1: update read request.
- update_rx, in, COORD_W: update read x.
- update_ry, in, COORD_W: update read y.
- update_rdata, out, 2: returned cell code.
- update_rvalid, out, 1: one-cycle pulse marking update_rdata valid.
- update_wenable, in, 1: update write request.
- update_wx, in, COORD_W: update write x.
- update_wy, in, COORD_W: update write y.
- update_wdata, in, 2: cell code to write.
- update_ready, out, 1: an update request is accepted in a cycle where it is asserted and update_ready is high.

Behaviour:
- Cell codes:
  - 0 VAZIO, colour 00/00/00.
  - 1 COBRA, colour 00/FF/00.
  - 2 FRUTA, colour FF/00/00.
  - 3 OBSTACULO, colour 80/80/80.
- Address: addr = y*MAPA_WIDTH + x. The RAM is single-port, one access per clock.
- Reset values (reset low):
  - FSM = INIT, init counter = 0, init_done = 0.
  - update_ready = 0, update_rvalid = 0, update_rdata = 0.
  - mapa_R/G/B = 0.
- FSM states:
  - INIT: writes one cell per cycle, addr 0 to W*H-1. Cell value is VAZIO, or per the Optional Feature. Then go to SERVE: 1200 cycles at default parameters. During INIT, update_ready = 0 and the renderer colour is forced to 0.
  - SERVE: normal service; init_done = 1.
  - Any state: clear = 1 goes to INIT with the counter set to 0 on the next edge. Any in-flight rvalid is suppressed.
- Port priority per cycle, highest first: INIT write > renderer read (vga_read) > update write > update read.
- update_ready (combinational) = SERVE && !vga_read && !clear.
- Renderer path:
  - vga_read at cycle N gives the colour of the cell at (renderer_rx, renderer_ry) on mapa_R/G/B at cycle N+1.
  - The colour is registered and held until the next vga_read.
  - A renderer read out of range (x >= W or y >= H) returns colour 0.
- Update write:
  - Accepted when wenable && update_ready. The RAM is updated at that edge.
  - An out-of-range write is accepted but discarded.
- Update read:
  - Accepted when renable && update_ready && !wenable.
  - update_rdata is valid with an update_rvalid pulse exactly 1 cycle after acceptance.
  - An out-of-range read returns OBSTACULO (3), so the snake treats the screen edge as a wall.
- Simultaneous renable and wenable: the write is accepted that cycle; the read must be held and is accepted at the next ready cycle. Read-after-write to the same cell returns the new value.
- Initiator rule: an unaccepted request must keep its address and data stable until accepted.
- No wrap-around on coordinates. The counter saturates at W*H-1 before leaving INIT.
- Reset mid-INIT or mid-read: asynchronous return to reset values. RAM contents are undefined until INIT completes.

Optional Feature:
- Macro: MAPA_BORDA_EN.
- Defined: INIT writes OBSTACULO to every cell with x==0, x==W-1, y==0 or y==H-1, and VAZIO elsewhere.
- Undefined: INIT writes VAZIO to all cells. The edges are still walls logically, via the out-of-range read rule.

Decomposition:
- Shared package mapa_pkg holds:
  - cell code constants (VAZIO, COBRA, FRUTA, OBSTACULO);
  - the colour lookup constants;
  - the default MAPA_WIDTH/MAPA_HEIGHT.
- One natural sub-module: mapa_ram, an inferred single-port synchronous RAM (ADDR_W x 2, registered read). The FSM, arbitration and colour mapping stay in mapa_responder.

Test Plan:
- Release reset, hold inputs idle -> init_done rises after exactly 1200 cycles. With MAPA_BORDA_EN, a read of (0,5) returns 3 and a read of (5,5) returns 0. Without it, both return 0.
- Write (10,7)=2, then read (10,7) -> update_rvalid pulses 1 cycle after acceptance with rdata=2. vga_read at (10,7) gives mapa_R/G/B=FF/00/00 the next cycle.
- Hold vga_read=1 for 4 cycles while renable=1 at (3,3) -> update_ready=0 for those 4 cycles. The read is accepted on the 5th cycle and rvalid follows on the 6th.
- Assert renable and wenable together, both at (4,4), with wdata=1 -> the write is accepted first; the held read is accepted next cycle and returns 1.
- Read at (40,0) and at (0,30) -> rdata=3. A write to (40,0) is acknowledged and changes no cell (cell (0,1), address 40, still reads its prior value).
- Pulse clear in SERVE after writing (2,2)=1, and separately pull reset low at INIT cycle 600 -> in both cases init_done=0 and update_ready=0 immediately. init_done returns 1200 cycles after release, and (2,2) reads back 0.

Source files
------------

// File: rtl/mapa_pkg.sv
// Shared definitions for the tile-map responder: cell codes, colour table,
// default board geometry and FSM state encoding.
package mapa_pkg;

   localparam int MAPA_WIDTH_DEF  = 40;
   localparam int MAPA_HEIGHT_DEF = 30;
   localparam int COORD_W_DEF     = 10;
   localparam int ADDR_W_DEF      = 11;

   localparam logic [1:0] CELL_VAZIO     = 2'd0;
   localparam logic [1:0] CELL_COBRA     = 2'd1;
   localparam logic [1:0] CELL_FRUTA     = 2'd2;
   localparam logic [1:0] CELL_OBSTACULO = 2'd3;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   localparam rgb_t RGB_VAZIO     = '{r: 8'h00, g: 8'h00, b: 8'h00};
   localparam rgb_t RGB_COBRA     = '{r: 8'h00, g: 8'hFF, b: 8'h00};
   localparam rgb_t RGB_FRUTA     = '{r: 8'hFF, g: 8'h00, b: 8'h00};
   localparam rgb_t RGB_OBSTACULO = '{r: 8'h80, g: 8'h80, b: 8'h80};

   typedef enum logic [0:0] {
      ST_INIT  = 1'b0,
      ST_SERVE = 1'b1
   } mapa_state_t;

   // Maps a cell code to its display colour.
   function automatic rgb_t cell_colour(input logic [1:0] code);
      rgb_t c;
      case (code)
         CELL_VAZIO:     c = RGB_VAZIO;
         CELL_COBRA:     c = RGB_COBRA;
         CELL_FRUTA:     c = RGB_FRUTA;
         CELL_OBSTACULO: c = RGB_OBSTACULO;
         default:        c = RGB_VAZIO;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mapa_responder_if.sv
// Game-update engine request port: read and write requests sharing one
// ready signal, plus the read-return path.
interface mapa_responder_if #(
   parameter int COORD_W = 10
);
   logic               update_renable;
   logic [COORD_W-1:0] update_rx;
   logic [COORD_W-1:0] update_ry;
   logic [1:0]         update_rdata;
   logic               update_rvalid;
   logic               update_wenable;
   logic [COORD_W-1:0] update_wx;
   logic [COORD_W-1:0] update_wy;
   logic [1:0]         update_wdata;
   logic               update_ready;

   modport master (
      output update_renable, update_rx, update_ry,
      output update_wenable, update_wx, update_wy, update_wdata,
      input  update_rdata, update_rvalid, update_ready
   );

   modport slave (
      input  update_renable, update_rx, update_ry,
      input  update_wenable, update_wx, update_wy, update_wdata,
      output update_rdata, update_rvalid, update_ready
   );
endinterface

// File: rtl/mapa_ram.sv
// Single-port synchronous tile RAM, 2 bits per cell, registered read.
module mapa_ram #(
   parameter int ADDR_W = 11
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [1:0]        wdata,
   output logic [1:0]        rdata
);
   logic [1:0] mem_r [0:(2**ADDR_W)-1];
   logic [1:0] rdata_r;

   // One access per cycle: optional write, read data registered every cycle.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[addr] <= wdata;
      end
      rdata_r <= mem_r[addr];
   end

   assign rdata = rdata_r;
endmodule

// File: rtl/mapa_responder.sv
// Tile-map responder: initialises the board, then arbitrates the single RAM
// port between the renderer colour read and the update engine.
// Optional build macro MAPA_BORDA_EN: INIT paints the board edge as OBSTACULO.
module mapa_responder
   import mapa_pkg::*;
#(
   parameter int MAPA_WIDTH  = MAPA_WIDTH_DEF,
   parameter int MAPA_HEIGHT = MAPA_HEIGHT_DEF,
   parameter int COORD_W     = COORD_W_DEF,
   parameter int ADDR_W      = ADDR_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   output logic               init_done,
   input  logic               vga_read,
   input  logic [COORD_W-1:0] renderer_rx,
   input  logic [COORD_W-1:0] renderer_ry,
   output logic [7:0]         mapa_R,
   output logic [7:0]         mapa_G,
   output logic [7:0]         mapa_B,
   mapa_responder_if.slave    upd
);
   localparam logic [COORD_W-1:0] W_C    = COORD_W'(MAPA_WIDTH);
   localparam logic [COORD_W-1:0] H_C    = COORD_W'(MAPA_HEIGHT);
   localparam logic [ADDR_W-1:0]  LAST_C = ADDR_W'(MAPA_WIDTH * MAPA_HEIGHT - 1);

   function automatic logic [ADDR_W-1:0] cell_addr(input logic [COORD_W-1:0] x,
                                                   input logic [COORD_W-1:0] y);
      return ADDR_W'(({{COORD_W{1'b0}}, y} * {{COORD_W{1'b0}}, W_C}) + {{COORD_W{1'b0}}, x});
   endfunction

   function automatic logic out_of_range(input logic [COORD_W-1:0] x,
                                         input logic [COORD_W-1:0] y);
      return (x >= W_C) || (y >= H_C);
   endfunction

   mapa_state_t       state_r;
   logic [ADDR_W-1:0] cnt_r;
   logic              init_done_r;
   logic              vga_pend_r, vga_oor_r;
   logic              rvalid_r, rd_oor_r;
   logic [1:0]        rdata_hold_r, rdata_s;
   rgb_t              colour_hold_r, colour_s;
   logic              ready_s, wr_acc_s, rd_acc_s;
   logic              ram_we_s;
   logic [ADDR_W-1:0] ram_addr_s;
   logic [1:0]        ram_wdata_s, ram_rdata_s, init_cell_s;

   assign ready_s  = (state_r == ST_SERVE) && !vga_read && !clear;
   assign wr_acc_s = ready_s && upd.update_wenable;
   assign rd_acc_s = ready_s && upd.update_renable && !upd.update_wenable;

`ifdef MAPA_BORDA_EN
   logic [COORD_W-1:0] init_x_r, init_y_r;

   // Edge cells of the board become walls during initialisation.
   always_comb begin
      init_cell_s = CELL_VAZIO;
      if ((init_x_r == COORD_W'(0)) || (init_x_r == W_C - COORD_W'(1)) ||
          (init_y_r == COORD_W'(0)) || (init_y_r == H_C - COORD_W'(1))) begin
         init_cell_s = CELL_OBSTACULO;
      end else begin
         init_cell_s = CELL_VAZIO;
      end
   end

   // Raster x/y position that tracks the linear init counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         init_x_r <= COORD_W'(0);
         init_y_r <= COORD_W'(0);
      end else if (clear || (state_r != ST_INIT)) begin
         init_x_r <= COORD_W'(0);
         init_y_r <= COORD_W'(0);
      end else if (init_x_r == W_C - COORD_W'(1)) begin
         init_x_r <= COORD_W'(0);
         init_y_r <= init_y_r + COORD_W'(1);
      end else begin
         init_x_r <= init_x_r + COORD_W'(1);
      end
   end
`else
   assign init_cell_s = CELL_VAZIO;
`endif

   // RAM port arbitration: INIT write > renderer read > update write > update read.
   always_comb begin
      ram_we_s    = 1'b0;
      ram_addr_s  = {ADDR_W{1'b0}};
      ram_wdata_s = CELL_VAZIO;
      if (state_r == ST_INIT) begin
         ram_we_s    = 1'b1;
         ram_addr_s  = cnt_r;
         ram_wdata_s = init_cell_s;
      end else if (vga_read) begin
         ram_addr_s = cell_addr(renderer_rx, renderer_ry);
      end else if (wr_acc_s) begin
         ram_we_s    = !out_of_range(upd.update_wx, upd.update_wy);
         ram_addr_s  = cell_addr(upd.update_wx, upd.update_wy);
         ram_wdata_s = upd.update_wdata;
      end else if (rd_acc_s) begin
         ram_addr_s = cell_addr(upd.update_rx, upd.update_ry);
      end else begin
         ram_addr_s = {ADDR_W{1'b0}};
      end
   end

   mapa_ram #(.ADDR_W(ADDR_W)) u_ram (
      .clk   (clk),
      .we    (ram_we_s),
      .addr  (ram_addr_s),
      .wdata (ram_wdata_s),
      .rdata (ram_rdata_s)
   );

   // Renderer colour: fresh RAM data after a read, held otherwise, black outside SERVE.
   always_comb begin
      colour_s = RGB_VAZIO;
      if (state_r != ST_SERVE) begin
         colour_s = RGB_VAZIO;
      end else if (vga_pend_r) begin
         if (vga_oor_r) begin
            colour_s = RGB_VAZIO;
         end else begin
            colour_s = cell_colour(ram_rdata_s);
         end
      end else begin
         colour_s = colour_hold_r;
      end
   end

   // Update read data: off-board reads return a wall so the snake stops at the edge.
   always_comb begin
      rdata_s = rdata_hold_r;
      if (rvalid_r) begin
         if (rd_oor_r) begin
            rdata_s = CELL_OBSTACULO;
         end else begin
            rdata_s = ram_rdata_s;
         end
      end else begin
         rdata_s = rdata_hold_r;
      end
   end

   // Control FSM, init counter and read-return pipeline registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r       <= ST_INIT;
         cnt_r         <= {ADDR_W{1'b0}};
         init_done_r   <= 1'b0;
         vga_pend_r    <= 1'b0;
         vga_oor_r     <= 1'b0;
         rvalid_r      <= 1'b0;
         rd_oor_r      <= 1'b0;
         rdata_hold_r  <= CELL_VAZIO;
         colour_hold_r <= RGB_VAZIO;
      end else if (clear) begin
         state_r       <= ST_INIT;
         cnt_r         <= {ADDR_W{1'b0}};
         init_done_r   <= 1'b0;
         vga_pend_r    <= 1'b0;
         rvalid_r      <= 1'b0;
         colour_hold_r <= RGB_VAZIO;
      end else begin
         case (state_r)
            ST_INIT: begin
               if (cnt_r == LAST_C) begin
                  state_r     <= ST_SERVE;
                  init_done_r <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
               end
            end
            ST_SERVE: begin
               state_r     <= ST_SERVE;
               init_done_r <= 1'b1;
            end
            default: begin
               state_r     <= ST_INIT;
               cnt_r       <= {ADDR_W{1'b0}};
               init_done_r <= 1'b0;
            end
         endcase
         vga_pend_r    <= vga_read && (state_r == ST_SERVE);
         vga_oor_r     <= out_of_range(renderer_rx, renderer_ry);
         rvalid_r      <= rd_acc_s;
         rd_oor_r      <= out_of_range(upd.update_rx, upd.update_ry);
         rdata_hold_r  <= rdata_s;
         colour_hold_r <= colour_s;
      end
   end

   assign init_done         = init_done_r;
   assign upd.update_ready  = ready_s;
   assign upd.update_rvalid = rvalid_r;
   assign upd.update_rdata  = rdata_s;
   assign mapa_R            = colour_s.r;
   assign mapa_G            = colour_s.g;
   assign mapa_B            = colour_s.b;
endmodule
